cv32e40p_apu_arbiter: RTL
=========================

// Module: cv32e40p_apu_arbiter
// PURPOSE
//  Shares one FPU (cv32e40p_fp_wrapper, APU req/gnt + rvalid protocol) between NUM_CORES cores.
//  Round-robin arbitration on requests. Winner's operands/op/flags are muxed to the FPU.
//  An in-order tag FIFO records which core issued each outstanding op and routes each rvalid back.
//  Sits between the cores' apu_* ports and the FPU wrapper, in place of the per-core FPU.
// PARAMETERS
//  NUM_CORES        2  requesting cores, >=2
//  MAX_OUTSTANDING  4  tag FIFO depth = max ops in flight in the FPU, power of 2, >=1
//  ID_W  $clog2(NUM_CORES)  core index width, derived (localparam)
// PORTS
//  clk_i              in   1                        clock
//  rst_i              in   1                        asynchronous reset, active-high
//  core_apu_req_i     in   NUM_CORES                per-core request
//  core_apu_gnt_o     out  NUM_CORES                per-core grant (one-hot or zero)
//  core_apu_operands_i in  NUM_CORES*APU_NARGS_CPU*32   per-core operands
//  core_apu_op_i      in   NUM_CORES*APU_WOP_CPU    per-core opcode
//  core_apu_flags_i   in   NUM_CORES*APU_NDSFLAGS_CPU   per-core downstream flags
//  core_apu_rvalid_o  out  NUM_CORES                per-core result valid (one-hot or zero)
//  core_apu_result_o  out  32                       result, broadcast to all cores
//  core_apu_rflags_o  out  APU_NUSFLAGS_CPU         result flags, broadcast to all cores
//  fpu_apu_req_o / fpu_apu_gnt_i  out/in  1         FPU request / grant
//  fpu_apu_operands_o out  APU_NARGS_CPU*32         muxed operands
//  fpu_apu_op_o, fpu_apu_flags_o  out               muxed op / flags
//  fpu_apu_rvalid_i, fpu_apu_result_i, fpu_apu_rflags_i  in   FPU response
//  busy_o             out  1                        FIFO not empty
//  outstanding_o      out  $clog2(MAX_OUTSTANDING+1)  FIFO occupancy
//  err_o              out  1                        sticky: rvalid received with nothing outstanding
// BEHAVIOUR
//  Reset values:
//   - State: IDLE, rr_ptr=0, FIFO empty, err_o=0.
//   - With all req low, every core_*/fpu_req output is 0.
//   - Mux data outputs are 0 when no grant is pending.
//  FSM:
//   - IDLE: winner = first requesting core at or after rr_ptr, cyclic order.
//     fpu_apu_req_o = (|core_apu_req_i) & !fifo_full.
//     If req is raised and gnt=0, latch winner and go to LOCKED.
//   - LOCKED: winner stays frozen until fpu_apu_gnt_i (APU rule: req is held until gnt).
//     Newly raised requests cannot preempt. Return to IDLE on gnt.
//  Grant:
//   - core_apu_gnt_o[w] = fpu_apu_req_o & fpu_apu_gnt_i, combinational, 0-cycle latency.
//   - On grant: push w into the FIFO; rr_ptr <= (w+1) mod NUM_CORES.
//   - No grant: rr_ptr holds.
//  Full:
//   - fifo_full forces fpu_apu_req_o=0; core gnt stays 0.
//   - No same-cycle pop bypass: a slot freed by rvalid is usable next cycle.
//   - If LOCKED while full (cannot occur: entry to LOCKED requires !full), hold the lock.
//  Response routing (combinational):
//   - On fpu_apu_rvalid_i, core_apu_rvalid_o[head]=1 and the FIFO pops.
//   - Result/flags pass through unregistered.
//   - FIFO empty but a grant in the same cycle (0-latency FPU): route to the granted core, no push/pop.
//   - FIFO empty and no grant: no rvalid to any core; set err_o (sticky until reset).
//  Simultaneous push and pop: occupancy unchanged; head advances, new tag written at tail.
//  Pointers wrap mod MAX_OUTSTANDING; occupancy counter is separate (distinguishes full from empty).
//  Reset mid-operation: tags are discarded. The FPU must share the reset; late rvalids set err_o.
// STRUCTURE
//  Package cv32e40p_apu_arb_pkg:
//   - typedef arb_state_e {IDLE, LOCKED}
//   - function rr_pick(req, ptr)
//   - APU widths reused from cv32e40p_apu_core_pkg
//  Sub-module cv32e40p_apu_arb_tag_fifo: ID_W wide, MAX_OUTSTANDING deep; push/pop/full/empty/count/head.
//  Top holds the FSM, rr_ptr and the muxes.
// TESTING
//  1. NUM_CORES=2, both req in the same cycle after reset, gnt=1 -> core0 granted, then core1 next cycle, alternating.
//  2. core1 req, gnt=0 for 3 cycles, core0 raises req in cycle 2 -> fpu operands stay core1's until gnt; core1 granted.
//  3. 4 grants with no rvalid (depth 4) -> fpu_apu_req_o=0, outstanding_o=4;
//     one rvalid -> core gets rvalid, req is reasserted the next cycle.
//  4. Issue order c0,c1,c0, then 3 rvalids with results 0xA,0xB,0xC ->
//     rvalid one-hot to c0,c1,c0 respectively; result 0xA/0xB/0xC on the matching cycle.
//  5. 0-latency: gnt and rvalid in the same cycle with FIFO empty -> rvalid to the granted core, outstanding_o stays 0, err_o=0.
//  6. rvalid with FIFO empty and no req -> err_o=1, holds;
//     rst_i pulse mid-burst (2 outstanding) -> outstanding_o=0, err_o=0, rr_ptr=0.

Source files
------------

// File: rtl/cv32e40p_apu_arb_pkg.sv
// cv32e40p_apu_arb_pkg: shared types, APU widths and the round-robin pick for the FPU arbiter
package cv32e40p_apu_arb_pkg;

    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;
    localparam int MAX_CORES        = 16;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    // Scanning downwards lets the closest requester at or after ptr overwrite the rest.
    function automatic int rr_pick(input logic [MAX_CORES-1:0] req, input int ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (ptr + k) % n;
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/cv32e40p_apu_arb_tag_fifo.sv
// cv32e40p_apu_arb_tag_fifo: in-order FIFO of issuing-core tags for ops in flight in the FPU
module cv32e40p_apu_arb_tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  tag_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push_i) r_wr <= nxt(r_wr);
            if (pop_i) r_rd <= nxt(r_rd);
            r_cnt <= r_cnt + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr] <= tag_i;
    end

    assign head_o  = r_mem[r_rd];
    assign full_o  = r_cnt == CW'(DEPTH);
    assign empty_o = r_cnt == '0;
    assign count_o = r_cnt;

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// cv32e40p_apu_arbiter: round-robin sharing of one APU/FPU between several cores, with in-order response routing
module cv32e40p_apu_arbiter
    import cv32e40p_apu_arb_pkg::*;
#(
    parameter int NUM_CORES       = 2,
    parameter int MAX_OUTSTANDING = 4,
    localparam int ID_W           = $clog2(NUM_CORES),
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1),
    localparam int ARG_W          = APU_NARGS_CPU * 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_CORES-1:0]                  core_apu_req_i,
    output logic [NUM_CORES-1:0]                  core_apu_gnt_o,
    input  logic [NUM_CORES*ARG_W-1:0]            core_apu_operands_i,
    input  logic [NUM_CORES*APU_WOP_CPU-1:0]      core_apu_op_i,
    input  logic [NUM_CORES*APU_NDSFLAGS_CPU-1:0] core_apu_flags_i,
    output logic [NUM_CORES-1:0]                  core_apu_rvalid_o,
    output logic [31:0]                           core_apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]           core_apu_rflags_o,
    output logic                                  fpu_apu_req_o,
    input  logic                                  fpu_apu_gnt_i,
    output logic [ARG_W-1:0]                      fpu_apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                fpu_apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]           fpu_apu_flags_o,
    input  logic                                  fpu_apu_rvalid_i,
    input  logic [31:0]                           fpu_apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]           fpu_apu_rflags_i,
    output logic                                  busy_o,
    output logic [OW-1:0]                         outstanding_o,
    output logic                                  err_o
);

    arb_state_e      r_state;
    arb_state_e      w_state_nxt;
    logic [ID_W-1:0] r_win;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_pick;
    logic [ID_W-1:0] w_win;
    logic [ID_W-1:0] w_head;
    logic            r_err;
    logic            w_full;
    logic            w_empty;
    logic            w_req;
    logic            w_gnt;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;

    assign w_pick   = ID_W'(rr_pick(MAX_CORES'(core_apu_req_i), int'(r_rr_ptr), NUM_CORES));
    assign w_win    = (r_state == LOCKED) ? r_win : w_pick;
    assign w_req    = (|core_apu_req_i) & ~w_full;
    assign w_gnt    = w_req & fpu_apu_gnt_i;
    // A zero-latency FPU answers the op being granted; it never touches the FIFO.
    assign w_bypass = fpu_apu_rvalid_i & w_empty & w_gnt;
    assign w_push   = w_gnt & ~w_bypass;
    assign w_pop    = fpu_apu_rvalid_i & ~w_empty;

    cv32e40p_apu_arb_tag_fifo #(
        .W     (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .tag_i   (w_win),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (outstanding_o)
    );

    assign fpu_apu_req_o     = w_req;
    assign core_apu_gnt_o    = w_gnt ? NUM_CORES'(1) << w_win : '0;
    assign core_apu_rvalid_o = w_pop ? NUM_CORES'(1) << w_head : w_bypass ? NUM_CORES'(1) << w_win : '0;
    assign core_apu_result_o = fpu_apu_result_i;
    assign core_apu_rflags_o = fpu_apu_rflags_i;
    assign busy_o            = ~w_empty;
    assign err_o             = r_err;

    always_comb begin
        fpu_apu_operands_o = '0;
        fpu_apu_op_o       = '0;
        fpu_apu_flags_o    = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (w_req && w_win == ID_W'(c)) begin
                fpu_apu_operands_o = core_apu_operands_i[c*ARG_W +: ARG_W];
                fpu_apu_op_o       = core_apu_op_i[c*APU_WOP_CPU +: APU_WOP_CPU];
                fpu_apu_flags_o    = core_apu_flags_i[c*APU_NDSFLAGS_CPU +: APU_NDSFLAGS_CPU];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == IDLE) ? ((w_req & ~fpu_apu_gnt_i) ? LOCKED : IDLE)
                                        : (w_gnt ? IDLE : LOCKED);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_win    <= '0;
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_state_nxt == LOCKED) r_win <= w_pick;
            if (w_gnt) r_rr_ptr <= (w_win == ID_W'(NUM_CORES - 1)) ? '0 : w_win + 1'b1;
            if (fpu_apu_rvalid_i & w_empty & ~w_gnt) r_err <= 1'b1;
        end
    end

endmodule
